// File: rtl/mtimer_if.sv
// Data-memory bus port of the machine timer: strobes, word select, byte lanes
// and the registered read-response pair.
interface mtimer_if;
    logic        sel;
    logic        we;
    logic        re;
    logic [1:0]  addr;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        rvalid;

    modport master (
        output sel, we, re, addr, be, wdata,
        input  rdata, rvalid
    );

    modport slave (
        input  sel, we, re, addr, be, wdata,
        output rdata, rvalid
    );
endinterface

// File: rtl/mtimer.sv
// RISC-V machine timer: prescaled 64-bit mtime, 64-bit mtimecmp, atomic lo/hi
// reads through a shadow word, and a registered level interrupt.
module mtimer #(
    parameter int PRESCALE = 1
) (
    input  logic clk,
    input  logic reset,
    mtimer_if.slave bus,
    output logic irq_mtimecmp
);

    localparam logic [15:0] LAST = 16'(PRESCALE - 1);

    logic [15:0] count;
    logic        tick;
    logic [63:0] mtime;
    logic [63:0] mtimecmp;
    logic [31:0] shadow;
    logic        shadow_valid;

    logic        wr;
    logic        rd;
    logic        time_wr;
    logic        cmp_wr;
    logic [31:0] wr_old;
    logic [31:0] wr_merged;
    logic [31:0] rd_word;

    assign tick    = (count == LAST);
    assign wr      = bus.sel & bus.we;
    assign rd      = bus.sel & bus.re;
    assign time_wr = wr & ~bus.addr[1];
    assign cmp_wr  = wr & bus.addr[1];

    always_comb begin
        wr_old = mtime[31:0];
        case (bus.addr)
            2'd0:    wr_old = mtime[31:0];
            2'd1:    wr_old = mtime[63:32];
            2'd2:    wr_old = mtimecmp[31:0];
            default: wr_old = mtimecmp[63:32];
        endcase
    end

    always_comb begin
        wr_merged = wr_old;
        for (int i = 0; i < 4; i++) begin
            if (bus.be[i]) begin
                wr_merged[8*i +: 8] = bus.wdata[8*i +: 8];
            end
        end
    end

    // Read mux uses pre-write register values, so a combined read+write returns old data.
    always_comb begin
        rd_word = mtime[31:0];
        case (bus.addr)
            2'd0:    rd_word = mtime[31:0];
            2'd1:    rd_word = shadow_valid ? shadow : mtime[63:32];
            2'd2:    rd_word = mtimecmp[31:0];
            default: rd_word = mtimecmp[63:32];
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
        end else if (tick) begin
            count <= '0;
        end else begin
            count <= count + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            mtime <= '0;
        end else if (time_wr) begin
            if (bus.addr[0]) begin
                mtime[63:32] <= wr_merged;
            end else begin
                mtime[31:0] <= wr_merged;
            end
        end else if (tick) begin
            mtime <= mtime + 64'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            mtimecmp <= '1;
        end else if (cmp_wr) begin
            if (bus.addr[0]) begin
                mtimecmp[63:32] <= wr_merged;
            end else begin
                mtimecmp[31:0] <= wr_merged;
            end
        end
    end

    // The later write-clear deliberately overrides the read's shadow update.
    always_ff @(posedge clk) begin
        if (reset) begin
            bus.rdata    <= '0;
            bus.rvalid   <= 1'b0;
            shadow       <= '0;
            shadow_valid <= 1'b0;
        end else begin
            bus.rvalid <= rd;
            if (rd) begin
                bus.rdata <= rd_word;
                if (bus.addr == 2'd0) begin
                    shadow       <= mtime[63:32];
                    shadow_valid <= 1'b1;
                end else if (bus.addr == 2'd1) begin
                    shadow_valid <= 1'b0;
                end
            end
            if (time_wr) begin
                shadow_valid <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            irq_mtimecmp <= 1'b0;
        end else begin
            irq_mtimecmp <= (mtime >= mtimecmp);
        end
    end

endmodule

// File: tb/tb_mtimer.sv
// Drives identical bus traffic into a PRESCALE=1 and a PRESCALE=4 timer and
// checks both against a cycle-level arithmetic model of the timer's rules.
module tb_mtimer;

    logic clk = 1'b0;
    logic reset;
    logic irq1;
    logic irq4;

    int total = 0;
    int bad   = 0;

    mtimer_if bus1 ();
    mtimer_if bus4 ();

    mtimer #(.PRESCALE(1)) dut1 (
        .clk          (clk),
        .reset        (reset),
        .bus          (bus1.slave),
        .irq_mtimecmp (irq1)
    );

    mtimer #(.PRESCALE(4)) dut4 (
        .clk          (clk),
        .reset        (reset),
        .bus          (bus4.slave),
        .irq_mtimecmp (irq4)
    );

    always #5 clk = ~clk;

    int                pv [2] = '{1, 4};
    logic [63:0]       m_time   [2];
    logic [63:0]       m_cmp    [2];
    logic [31:0]       m_shadow [2];
    logic [31:0]       m_rdata  [2];
    logic              m_sv     [2];
    logic              m_rvalid [2];
    logic              m_irq    [2];
    longint unsigned   m_cyc    [2];

    function automatic logic [31:0] byteMerge(logic [31:0] old_w, logic [31:0] new_w, logic [3:0] lanes);
        logic [31:0] r;
        r = old_w;
        for (int i = 0; i < 4; i++) begin
            if (lanes[i]) r[8*i +: 8] = new_w[8*i +: 8];
        end
        return r;
    endfunction

    // Advances model k by one clock edge using only pre-edge state.
    task automatic modelStep(int k, logic rst, logic sel, logic we, logic re,
                             logic [1:0] addr, logic [3:0] be, logic [31:0] wdata);
        logic [63:0] t;
        logic [63:0] c;
        logic        tick;
        if (rst) begin
            m_time[k] = 64'd0;  m_cmp[k] = '1;  m_shadow[k] = 32'd0;  m_sv[k] = 1'b0;
            m_rdata[k] = 32'd0; m_rvalid[k] = 1'b0; m_irq[k] = 1'b0;   m_cyc[k] = 0;
            return;
        end
        tick = ((m_cyc[k] % longint'(pv[k])) == longint'(pv[k] - 1));
        t = m_time[k];
        c = m_cmp[k];
        m_irq[k]    = (m_time[k] >= m_cmp[k]);
        m_rvalid[k] = sel && re;
        if (sel && re) begin
            case (addr)
                2'd0: begin m_rdata[k] = t[31:0]; m_shadow[k] = t[63:32]; m_sv[k] = 1'b1; end
                2'd1: begin m_rdata[k] = m_sv[k] ? m_shadow[k] : t[63:32]; m_sv[k] = 1'b0; end
                2'd2: m_rdata[k] = c[31:0];
                default: m_rdata[k] = c[63:32];
            endcase
        end
        if (sel && we) begin
            case (addr)
                2'd0: begin m_time[k][31:0]  = byteMerge(t[31:0], wdata, be);  m_sv[k] = 1'b0; end
                2'd1: begin m_time[k][63:32] = byteMerge(t[63:32], wdata, be); m_sv[k] = 1'b0; end
                2'd2: m_cmp[k][31:0]  = byteMerge(c[31:0], wdata, be);
                default: m_cmp[k][63:32] = byteMerge(c[63:32], wdata, be);
            endcase
        end
        if (!(sel && we && !addr[1]) && tick) m_time[k] = t + 64'd1;
        m_cyc[k] = m_cyc[k] + 1;
    endtask

    task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("[TB] FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic checkOutput();
        check("d1 rdata",  bus1.rdata,           m_rdata[0]);
        check("d1 rvalid", {31'd0, bus1.rvalid}, {31'd0, m_rvalid[0]});
        check("d1 irq",    {31'd0, irq1},        {31'd0, m_irq[0]});
        check("d4 rdata",  bus4.rdata,           m_rdata[1]);
        check("d4 rvalid", {31'd0, bus4.rvalid}, {31'd0, m_rvalid[1]});
        check("d4 irq",    {31'd0, irq4},        {31'd0, m_irq[1]});
    endtask

    // One clock cycle: drive both buses, step both models, check after the edge.
    task automatic applyStimulus(logic rst, logic sel, logic we, logic re,
                                 logic [1:0] addr, logic [3:0] be, logic [31:0] wdata);
        reset = rst;
        bus1.sel = sel; bus1.we = we; bus1.re = re; bus1.addr = addr; bus1.be = be; bus1.wdata = wdata;
        bus4.sel = sel; bus4.we = we; bus4.re = re; bus4.addr = addr; bus4.be = be; bus4.wdata = wdata;
        modelStep(0, rst, sel, we, re, addr, be, wdata);
        modelStep(1, rst, sel, we, re, addr, be, wdata);
        @(posedge clk);
        #1;
        checkOutput();
    endtask

    task automatic idle(int n);
        for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 4'h0, 32'd0);
    endtask

    task automatic wrWord(logic [1:0] addr, logic [3:0] be, logic [31:0] data);
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, addr, be, data);
    endtask

    task automatic rdWord(logic [1:0] addr);
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b1, addr, 4'h0, 32'd0);
    endtask

    initial begin
        reset = 1'b1;
        bus1.sel = 1'b0; bus1.we = 1'b0; bus1.re = 1'b0; bus1.addr = 2'd0; bus1.be = 4'h0; bus1.wdata = 32'd0;
        bus4.sel = 1'b0; bus4.we = 1'b0; bus4.re = 1'b0; bus4.addr = 2'd0; bus4.be = 4'h0; bus4.wdata = 32'd0;
        @(posedge clk);
        #1;

        $display("[TB] reset values");
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 4'h0, 32'd0);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 4'h0, 32'd0);
        check("reset irq", {31'd0, irq1}, 32'd0);
        rdWord(2'd0); check("reset mtime lo",    bus1.rdata, 32'h0000_0000);
        rdWord(2'd1); check("reset mtime hi",    bus1.rdata, 32'h0000_0000);
        rdWord(2'd2); check("reset mtimecmp lo", bus1.rdata, 32'hFFFF_FFFF);
        rdWord(2'd3); check("reset mtimecmp hi", bus1.rdata, 32'hFFFF_FFFF);

        $display("[TB] prescaler");
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 4'h0, 32'd0);
        idle(40);
        rdWord(2'd0);
        check("prescale4 count", bus4.rdata, 32'd10);
        check("prescale1 count", bus1.rdata, 32'd40);

        $display("[TB] carry and atomic read");
        wrWord(2'd0, 4'hF, 32'hFFFF_FFFE);
        wrWord(2'd1, 4'hF, 32'h0000_0005);
        rdWord(2'd0);
        check("carry lo", bus1.rdata, 32'hFFFF_FFFE);
        idle(10);
        rdWord(2'd1);
        check("shadow hi", bus1.rdata, 32'h0000_0005);
        rdWord(2'd1);
        check("live hi", bus1.rdata, 32'h0000_0006);

        $display("[TB] byte enables");
        wrWord(2'd2, 4'hF, 32'hFFFF_FFFF);
        wrWord(2'd2, 4'b0101, 32'hAABB_CCDD);
        rdWord(2'd2);
        check("byte lanes", bus1.rdata, 32'hFFBB_FFDD);
        idle(3);
        wrWord(2'd0, 4'b0011, 32'h0000_1234);
        rdWord(2'd0);

        $display("[TB] interrupt");
        wrWord(2'd3, 4'hF, 32'd0);
        wrWord(2'd2, 4'hF, 32'd20);
        wrWord(2'd1, 4'hF, 32'd0);
        wrWord(2'd0, 4'hF, 32'd0);
        idle(19);
        check("irq before match", {31'd0, irq1}, 32'd0);
        idle(2);
        check("irq after match", {31'd0, irq1}, 32'd1);
        idle(5);
        wrWord(2'd3, 4'hF, 32'd1);
        idle(1);
        check("irq cleared", {31'd0, irq1}, 32'd0);

        $display("[TB] wrap and reset collision");
        wrWord(2'd2, 4'hF, 32'hFFFF_FFFF);
        wrWord(2'd3, 4'hF, 32'hFFFF_FFFF);
        wrWord(2'd0, 4'hF, 32'hFFFF_FFFF);
        wrWord(2'd1, 4'hF, 32'hFFFF_FFFF);
        idle(1);
        check("irq at max", {31'd0, irq1}, 32'd1);
        idle(1);
        check("irq after wrap", {31'd0, irq1}, 32'd0);
        idle(6);
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b1, 2'd2, 4'hF, 32'h0000_0000);
        check("rvalid after reset", {31'd0, bus1.rvalid}, 32'd0);
        rdWord(2'd2);
        check("write discarded by reset", bus1.rdata, 32'hFFFF_FFFF);

        $display("[TB] randomized traffic");
        for (int i = 0; i < 600; i++) begin
            logic        r_sel;
            logic        r_rst;
            logic [31:0] r_data;
            logic [1:0]  r_addr;
            r_rst  = ($urandom_range(0, 149) == 0);
            r_sel  = ($urandom_range(0, 3) != 0);
            r_addr = 2'($urandom_range(0, 3));
            r_data = $urandom;
            if (r_addr[0] && $urandom_range(0, 1) == 1) r_data = 32'($urandom_range(0, 2));
            applyStimulus(r_rst, r_sel, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                          r_addr, 4'($urandom_range(0, 15)), r_data);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mtimer.md
# mtimer

Memory-mapped RISC-V machine timer: the source end of the `irq_mtimecmp` line consumed by the CSR/exception unit. Holds the 64-bit `mtime` counter, advanced by a programmable prescaler, and the 64-bit `mtimecmp` compare register. Both are exposed as four 32-bit words on the core's data-memory port. Drives a registered, level-sensitive `irq_mtimecmp` while `mtime >= mtimecmp`.

## Interface
- `PRESCALE`, default 1: core clock cycles per `mtime` increment. Legal range 1..65535.
- `clk` input 1: core clock. All state updates on the rising edge.
- `reset` input 1: synchronous reset, active-high.
- `sel` input 1: block selected for the current bus cycle.
- `we` input 1: write strobe. Qualified by `sel`.
- `re` input 1: read strobe. Qualified by `sel`.
- `addr` input 2: word select, taken from the core's address bits [3:2]. 0 = `mtime` lo, 1 = `mtime` hi, 2 = `mtimecmp` lo, 3 = `mtimecmp` hi.
- `be` input 4: byte-lane enables for writes. `be[i]` covers `wdata[8i+7:8i]`.
- `wdata` input 32: write data.
- `rdata` output 32: registered read data.
- `rvalid` output 1: `rdata` is valid this cycle.
- `irq_mtimecmp` output 1: timer interrupt request, level, registered.

## Operation
- **Reset values.**
  - `mtime` = 0.
  - `mtimecmp` = 64'hFFFF_FFFF_FFFF_FFFF, so no interrupt is raised after reset.
  - Prescaler count = 0.
  - Shadow-valid = 0.
  - `rdata` = 0, `rvalid` = 0, `irq_mtimecmp` = 0.
- **Prescaler.**
  - A 16-bit count runs 0..PRESCALE-1 and wraps to 0.
  - `tick` = (count == PRESCALE-1).
  - With PRESCALE=1, `tick` is asserted every cycle.
  - The prescaler is never affected by bus writes.
- **mtime.**
  - Increments by 1 on `tick`. Wraps from 2^64-1 to 0 with no flag.
  - Any cycle with `sel & we` to addr 0 or 1 suppresses that cycle's increment.
  - On such a write, enabled bytes take `wdata` and disabled bytes keep their old value.
- **mtimecmp.**
  - Byte-enabled writes at addr 2/3. No other side effects.
- **Reads.**
  - On `sel & re`, `rdata` is loaded next edge and `rvalid` pulses high for exactly one cycle.
  - Reading addr 0 returns `mtime[31:0]`. It also copies `mtime[63:32]` into a 32-bit shadow and sets shadow-valid.
  - Reading addr 1 returns the shadow if shadow-valid, else live `mtime[63:32]`. It then clears shadow-valid.
  - Result: a lo-then-hi read pair is atomic.
  - Any write to addr 0/1 clears shadow-valid.
  - Reads of addr 2/3 return `mtimecmp` halves with no side effects.
- **Simultaneous read and write.** `re & we` in the same cycle:
  - The write takes effect.
  - `rdata` returns the pre-write value.
  - Shadow effects are applied in this order: the read's shadow effect first, then the write clears shadow-valid.
- **Idle bus.** With `sel` low, `re`/`we` are ignored and `rdata` holds its last value.
- **Interrupt.**
  - `irq_mtimecmp` <= (`mtime` >= `mtimecmp`), an unsigned 64-bit compare of current register values, every cycle.
  - No latching: writing `mtimecmp` above `mtime` deasserts the output.

## Timing
- Read latency: 1 cycle. Request at edge N, `rdata`/`rvalid` valid after edge N+1. Back-to-back reads every cycle are supported.
- Writes are visible to a read issued the following cycle.
- `irq_mtimecmp` lags the register state by 1 cycle.
  - Increment at edge N makes `mtime == mtimecmp`; `irq` rises after edge N+1.
  - A `mtimecmp` write at edge N clears `irq` after edge N+1.
- `reset` asserted mid-operation overrides everything on that edge, including a concurrent write or read. `rvalid` is 0 the following cycle.
- Critical path: the 64-bit compare. It is registered and must not feed `rdata` combinationally.

## Test plan
1. **Reset.** Reset 2 cycles, then read addr 0..3 -> 0, 0, 0xFFFFFFFF, 0xFFFFFFFF. `irq_mtimecmp` = 0 throughout.
2. **Prescaler and increment.** PRESCALE=4: release reset, wait 40 cycles, read addr 0 -> 10 (±1 for request cycle alignment). Repeat with PRESCALE=1 -> one increment per cycle.
3. **Carry and atomic read.**
   - Write addr 0 = 0xFFFFFFFE, addr 1 = 0x00000005. Read addr 0, wait 10 cycles, read addr 1 -> 0x00000005, the shadow, despite the carry.
   - A second read of addr 1 -> 0x00000006.
4. **Byte enables.** Write addr 2 = 0xAABBCCDD with `be`=0101 over 0xFFFFFFFF -> read returns 0xFFBBFFDD. A write to addr 0 in a tick cycle -> no increment lost or doubled beyond spec.
5. **Interrupt.**
   - `mtime`=0, write `mtimecmp` = {0, 20}, PRESCALE=1 -> `irq` rises exactly 1 cycle after `mtime` reaches 20 and stays high.
   - Write `mtimecmp` hi = 1 -> `irq` drops the next cycle.
6. **Wrap and reset collisions.**
   - Set `mtime` = 2^64-1, `mtimecmp` = 2^64-1 -> `irq` high, then `mtime` wraps to 0 and `irq` falls.
   - Assert `reset` in the same cycle as a write -> all reset values, and the write is discarded.
